// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline requesters, the arbiter and the shared memory.
// The slave view belongs to the arbiter; the master view is the surrounding pipeline and memory.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              ram_req;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              ram_ready;
   logic              stall;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata, ram_ready,
      output if_rdata, if_ack, mem_rdata, mem_ack, ram_req, ram_we, ram_addr, ram_wdata, stall
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata, ram_ready,
      input  if_rdata, if_ack, mem_rdata, mem_ack, ram_req, ram_we, ram_addr, ram_wdata, stall
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency single-port memory between instruction fetch and the MEM stage.
// MEM has fixed priority; fetch is forced through after STARVE_LIMIT consecutive MEM grants.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY_MEM, BUSY_IF, DONE} state_t;

   state_t            state_reg;
   logic              ram_req_reg;
   logic              ram_we_reg;
   logic [ADDR_W-1:0] ram_addr_reg;
   logic [DATA_W-1:0] ram_wdata_reg;
   logic [DATA_W-1:0] if_rdata_reg;
   logic [DATA_W-1:0] mem_rdata_reg;
   logic              if_ack_reg;
   logic              mem_ack_reg;
   logic [3:0]        starve_cnt_reg;

   logic if_live;
   logic mem_live;
   logic mem_wins;

   // A requester whose ack is showing is finishing, not asking again.
   assign if_live  = bus.if_req & ~if_ack_reg;
   assign mem_live = bus.mem_req & ~mem_ack_reg;
   assign mem_wins = mem_live & (~if_live | (starve_cnt_reg < 4'(STARVE_LIMIT)));

   assign bus.ram_req   = ram_req_reg;
   assign bus.ram_we    = ram_we_reg;
   assign bus.ram_addr  = ram_addr_reg;
   assign bus.ram_wdata = ram_wdata_reg;
   assign bus.if_rdata  = if_rdata_reg;
   assign bus.mem_rdata = mem_rdata_reg;
   assign bus.if_ack    = if_ack_reg;
   assign bus.mem_ack   = mem_ack_reg;
   assign bus.stall     = if_live | mem_live;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         ram_req_reg    <= 1'b0;
         ram_we_reg     <= 1'b0;
         ram_addr_reg   <= '0;
         ram_wdata_reg  <= '0;
         if_rdata_reg   <= '0;
         mem_rdata_reg  <= '0;
         if_ack_reg     <= 1'b0;
         mem_ack_reg    <= 1'b0;
         starve_cnt_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (mem_wins) begin
                  state_reg     <= BUSY_MEM;
                  ram_req_reg   <= 1'b1;
                  ram_we_reg    <= bus.mem_we;
                  ram_addr_reg  <= bus.mem_addr;
                  ram_wdata_reg <= bus.mem_wdata;
                  // mem_wins with fetch waiting implies count < limit, so this saturates at the limit
                  starve_cnt_reg <= if_live ? starve_cnt_reg + 4'd1 : 4'd0;
               end else if (if_live) begin
                  state_reg      <= BUSY_IF;
                  ram_req_reg    <= 1'b1;
                  ram_we_reg     <= 1'b0;
                  ram_addr_reg   <= bus.if_addr;
                  ram_wdata_reg  <= '0;
                  starve_cnt_reg <= '0;
               end
            end
            BUSY_MEM: begin
               if (bus.ram_ready) begin
                  state_reg   <= DONE;
                  ram_req_reg <= 1'b0;
                  ram_we_reg  <= 1'b0;
                  mem_ack_reg <= 1'b1;
                  if (!ram_we_reg) begin
                     mem_rdata_reg <= bus.ram_rdata;
                  end
               end
            end
            BUSY_IF: begin
               if (bus.ram_ready) begin
                  state_reg    <= DONE;
                  ram_req_reg  <= 1'b0;
                  ram_we_reg   <= 1'b0;
                  if_ack_reg   <= 1'b1;
                  if_rdata_reg <= bus.ram_rdata;
               end
            end
            DONE: begin
               state_reg   <= IDLE;
               if_ack_reg  <= 1'b0;
               mem_ack_reg <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end
endmodule
